// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart block, the uart_tx_feeder in front of it and
// their benches.
//
// Contents:
//   C_CLK_HZ        system clock frequency (clk_50m)
//   C_BAUD          serial line rate
//   C_CLKS_PER_BIT  clk_50m cycles per serial bit
//   feeder_state_t  state encoding of the uart_tx_feeder pacing FSM
//   ptr_width()     pointer width for a power-of-two FIFO with a wrap bit
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int C_CLK_HZ       = 50_000_000;
   localparam int C_BAUD         = 115200;
   localparam int C_CLKS_PER_BIT = C_CLK_HZ / C_BAUD;

   // IDLE      : waiting for a byte and an idle transmitter
   // LOAD      : byte presented on uart_din, wr_en pulsed for this one cycle
   // WAIT_BUSY : waiting for the uart to acknowledge by raising tx_busy
   // WAIT_DONE : frame on the wire, waiting for tx_busy to fall
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } feeder_state_t;

   // One extra bit above the address lets full and empty be told apart when
   // the read and write addresses coincide.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with show-ahead read: rdata always shows the head entry
// while the FIFO is not empty, so a pop consumes the value already visible.
//
// Parameters:
//   DATA_W  entry width
//   DEPTH   number of entries; must be a power of two, at least 2
//
// Ports:
//   clk_50m  in   system clock
//   rst_n    in   asynchronous active-low reset; empties the FIFO
//   push     in   write wdata this cycle (ignored when full)
//   wdata    in   data to write
//   pop      in   discard the head this cycle (ignored when empty)
//   rdata    out  head entry (valid when !empty)
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   level    out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                       clk_50m,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       pop,
   output logic [DATA_W-1:0]          rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   // The FIFO protects itself: a push while full or a pop while empty is
   // ignored, whatever the caller does.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Same address with different wrap bits means the writer has lapped the
   // reader exactly once.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // Modulo-2^PW difference of the pointers is the occupancy, including the
   // DEPTH case when full.
   assign level = wr_ptr - rd_ptr;

   assign rdata = mem[rd_ptr[AW-1:0]];

   // Pointer update; both may move in the same cycle.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Storage is not reset: an entry is only ever read after it was written.
   always_ff @(posedge clk_50m) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Buffers bytes from a producer and feeds them to the uart transmitter one
// frame at a time, so the producer can burst without watching tx_busy.
//
// Parameters:
//   DATA_W        byte width (8 for the uart)
//   DEPTH         FIFO entries; power of two, at least 2
//   BUSY_TIMEOUT  cycles to wait for tx_busy after a wr_en pulse before the
//                 byte is treated as sent
//
// Ports:
//   clk_50m       in   system clock
//   rst_n         in   asynchronous active-low reset
//   s_data        in   byte from the producer
//   s_valid       in   producer has a byte
//   s_ready       out  FIFO can accept a byte (!full)
//   uart_din      out  byte to the uart, registered, changes only on a pop
//   uart_wr_en    out  single-cycle write strobe to the uart
//   uart_tx_busy  in   uart is shifting out a frame
//   level         out  FIFO occupancy
//   overflow      out  one-cycle pulse after a byte was offered while full
// -----------------------------------------------------------------------------
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic                       clk_50m,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [DATA_W-1:0]          uart_din,
   output logic                       uart_wr_en,
   input  logic                       uart_tx_busy,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   feeder_state_t     state;
   logic [CNT_W-1:0]  busy_cnt;

   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;

   // s_ready comes straight from the registered full flag, so a pop in the
   // same cycle never lets an extra byte in.
   assign s_ready   = !fifo_full;
   assign fifo_push = s_valid && s_ready;

   // Popping only from IDLE with tx_busy low is what keeps wr_en away from a
   // busy transmitter, including one still finishing a frame across a reset.
   assign fifo_pop  = (state == IDLE) && !fifo_empty && !uart_tx_busy;

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .wdata   (s_data),
      .pop     (fifo_pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   // Pacing FSM. uart_wr_en is registered and set on the pop edge, so it is
   // high for exactly the LOAD cycle and the uart samples it at the end of it.
   // WAIT_BUSY lasts at most BUSY_TIMEOUT cycles; an unacknowledged byte is
   // dropped rather than retried.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         uart_din   <= '0;
         uart_wr_en <= 1'b0;
         busy_cnt   <= '0;
      end else begin
         uart_wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  uart_din   <= fifo_rdata;
                  uart_wr_en <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               busy_cnt <= '0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (uart_tx_busy) begin
                  state <= WAIT_DONE;
               end else if (busy_cnt == CNT_LAST) begin
                  state <= IDLE;
               end else begin
                  busy_cnt <= busy_cnt + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!uart_tx_busy) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A byte offered while full is dropped; flag it for one cycle.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else begin
         overflow <= s_valid && !s_ready;
      end
   end

endmodule : uart_tx_feeder
